instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Per-core instruction fetch stage sitting directly upstream of the decoder. When the core scheduler enters FETCH it returns the 16-bit instruction at `current_pc`, either from a small direct-mapped instruction buffer (1-cycle hit) or via the valid/ready handshake to the program-memory controller. It holds the instruction stable through DECODE and reports completion through `fetcher_state`. Each core has its own instance.

## Interface
- `PROGRAM_MEM_ADDR_BITS`, 8, PC / program-memory address width
- `PROGRAM_MEM_DATA_BITS`, 16, instruction width
- `IBUF_LINES`, 4, direct-mapped buffer entries; power of two, ≥2; one instruction per line
- `clk`  in  1  clock, single clock domain
- `reset`  in  1  synchronous, active-high
- `core_state`  in  3  scheduler state: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
- `current_pc`  in  ADDR  PC to fetch; sampled when the fetch starts
- `flush`  in  1  invalidate all buffer lines (kernel launch / program reload)
- `mem_read_valid`  out  1  program-memory read request
- `mem_read_address`  out  ADDR  request address
- `mem_read_ready`  in  1  response strobe; data valid this cycle
- `mem_read_data`  in  DATA  response instruction
- `fetcher_state`  out  3  IDLE=000, FETCHING=001, FETCHED=010
- `instruction`  out  DATA  fetched instruction, to decoder
- `hit_count`, `miss_count`  out  16 each  saturating performance counters

## Operation
- Index = `current_pc[log2(IBUF_LINES)-1:0]`; tag = remaining upper PC bits. Each line holds a valid bit, tag, and data.
- IDLE and `core_state`==FETCH:
  - Hit (valid and tag match): `instruction` <= line data; go to FETCHED; `hit_count`++.
  - Miss: `mem_read_valid` <= 1; `mem_read_address` <= `current_pc`; go to FETCHING; `miss_count`++.
- FETCHING:
  - Hold `mem_read_valid` and `mem_read_address` stable until `mem_read_ready`.
  - On ready: `instruction` <= `mem_read_data`; `mem_read_valid` <= 0; write the line (valid, tag, data); go to FETCHED.
- FETCHED and `core_state`==DECODE: go to IDLE. `instruction` keeps its value until the next fetch completes, so the decoder's sample is always stable.
- `flush`: clears all valid bits in the same cycle.
  - An in-flight request is not cancelled; the response is still delivered to `instruction`.
  - A line fill in the same cycle as `flush`, or while a flush has occurred during FETCHING, is suppressed.
  - A lookup in the flush cycle is a miss.
- Counters saturate at 16'hFFFF. They clear only on reset.
- PC wrap is natural: address arithmetic is modulo 2^ADDR and there is no special case.

## Timing
- Reset values: `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, all valid bits=0, counters=0. Tag and data arrays need not be reset.
- Hit: FETCH seen at cycle T gives FETCHED and valid `instruction` at T+1.
- Miss: FETCH seen at T gives `mem_read_valid`=1 at T+1. Ready seen at cycle R gives FETCHED, `instruction` valid, and `mem_read_valid`=0 at R+1.
- `mem_read_ready` is ignored outside FETCHING.
- If `core_state` leaves FETCH while FETCHING, the request still completes. `core_state`≠DECODE while FETCHED holds FETCHED.
- Reset asserted mid-FETCHING drops the request immediately (`mem_read_valid`=0 next edge). The memory controller is reset in the same cycle.

## Structure
- Shared core package holds:
  - `core_state` encodings (already used by the decoder, DECODE=010)
  - `fetcher_state` encodings
  - opcode width constant
- One natural sub-module: `ibuf_dm`, the direct-mapped tag/valid/data array with a combinational lookup and a registered fill/flush port. The FSM and counters live in `instruction_fetcher`.

## Test plan
- Cold miss: reset, PC=0x05, FETCH with ready 3 cycles after request. Expect `mem_read_address`=0x05, valid held 3 cycles, then FETCHED with `instruction`=0x3123 (memory data), `miss_count`=1.
- Hit: refetch PC=0x05 after DECODE→IDLE. Expect no `mem_read_valid`, FETCHED one cycle after FETCH, `instruction`=0x3123, `hit_count`=1.
- Conflict: fetch 0x01 then 0x05 (same index, IBUF_LINES=4), then 0x01. Expect 3 misses; the last request carries address 0x01.
- Flush race: `flush` during FETCHING of 0x07, ready afterward. Expect `instruction` delivered, but the next fetch of 0x07 misses.
- Reset mid-FETCHING: expect all outputs at reset values next edge. A subsequent fetch restarts cleanly with a miss.
- Saturation and stability: force 65,536+ hits. Expect `hit_count` stays at 0xFFFF. `instruction` is unchanged while DECODE is held multiple cycles and while `mem_read_ready` pulses in IDLE.

Source files
------------

// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: shared core encodings and fetch-stage constants
package instruction_fetcher_pkg;
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetcher_state_e;

    localparam int OPCODE_BITS     = 4;
    localparam int PERF_COUNT_BITS = 16;
endpackage

// File: rtl/instruction_fetcher_ibuf_dm.sv
// ibuf_dm: direct-mapped instruction buffer, combinational lookup, registered fill/flush
module ibuf_dm
    import instruction_fetcher_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_pc_i,
    output logic                 hit_o,
    output logic [DATA_BITS-1:0] data_o,
    input  logic                 flush_i,
    input  logic                 fill_i,
    input  logic [ADDR_BITS-1:0] fill_pc_i,
    input  logic [DATA_BITS-1:0] fill_data_i
);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    logic [IDX_BITS-1:0] lookup_idx, fill_idx;
    logic [TAG_BITS-1:0] lookup_tag, fill_tag;

    assign lookup_idx = lookup_pc_i[IDX_BITS-1:0];
    assign lookup_tag = lookup_pc_i[ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = fill_pc_i[IDX_BITS-1:0];
    assign fill_tag   = fill_pc_i[ADDR_BITS-1:IDX_BITS];

    // a lookup coinciding with flush must miss, since the line is being invalidated
    assign hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag) && !flush_i;
    assign data_o = data_q[lookup_idx];

    // valid bits: cleared by reset or flush, set by a fill that does not race a flush
    always_ff @(posedge clk) begin
        if (reset || flush_i) valid_q <= '0;
        else if (fill_i) valid_q[fill_idx] <= 1'b1;
    end

    // tag/data storage needs no reset; valid bits guard it
    always_ff @(posedge clk) begin
        if (fill_i && !flush_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_i;
        end
    end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch stage with instruction buffer, memory handshake and perf counters
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int IBUF_LINES            = 4,
    parameter int COUNT_BITS            = PERF_COUNT_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);
    fetcher_state_e                   state_q, state_d;
    logic                             req_valid_q, req_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic [COUNT_BITS-1:0]            hit_cnt_q, hit_cnt_d;
    logic [COUNT_BITS-1:0]            miss_cnt_q, miss_cnt_d;
    logic                             flushed_q, flushed_d;

    logic                             buf_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;
    logic                             fill;

    ibuf_dm #(
        .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS(PROGRAM_MEM_DATA_BITS),
        .LINES    (IBUF_LINES)
    ) u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc_i(current_pc),
        .hit_o      (buf_hit),
        .data_o     (buf_data),
        .flush_i    (flush),
        .fill_i     (fill),
        .fill_pc_i  (req_addr_q),
        .fill_data_i(mem_read_data)
    );

    // state, request and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            instr_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            flushed_q   <= flushed_d;
        end
    end

    // next state: lookup on FETCH, wait for memory on a miss, release on DECODE;
    // a flush seen while a request is outstanding keeps its stale response out of the buffer
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        instr_d     = instr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        flushed_d   = flushed_q;
        fill        = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit) begin
                        instr_d   = buf_data;
                        state_d   = FS_FETCHED;
                        hit_cnt_d = &hit_cnt_q ? hit_cnt_q : hit_cnt_q + COUNT_BITS'(1);
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = current_pc;
                        state_d     = FS_FETCHING;
                        flushed_d   = flush;
                        miss_cnt_d  = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + COUNT_BITS'(1);
                    end
                end
            end
            FS_FETCHING: begin
                flushed_d = flushed_q | flush;
                if (mem_read_ready) begin
                    instr_d     = mem_read_data;
                    req_valid_d = 1'b0;
                    fill        = !flush && !flushed_q;
                    state_d     = FS_FETCHED;
                end
            end
            FS_FETCHED: state_d = (core_state == CORE_DECODE) ? FS_IDLE : FS_FETCHED;
            default:    state_d = FS_IDLE;
        endcase
    end

    assign mem_read_valid   = req_valid_q;
    assign mem_read_address = req_addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: scenario tasks plus randomized fetches against a PC-set cache model
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  core_state = CORE_IDLE;
    logic [7:0]  current_pc = '0;
    logic        flush = 1'b0;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = '0;

    logic        mem_read_valid, s_mem_read_valid;
    logic [7:0]  mem_read_address, s_mem_read_address;
    logic [2:0]  fetcher_state, s_fetcher_state;
    logic [15:0] instruction, s_instruction;
    logic [15:0] hit_count, miss_count;
    logic [3:0]  s_hit_count, s_miss_count;

    instruction_fetcher dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state), .instruction(instruction),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // narrow-counter copy on the same stimulus so saturation is reachable in a short run
    instruction_fetcher #(.COUNT_BITS(4)) dut_sat (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
        .mem_read_valid(s_mem_read_valid), .mem_read_address(s_mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(s_fetcher_state), .instruction(s_instruction),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] prog [256];
    bit          cached [256];
    int          hits = 0;
    int          misses = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: the buffer is the set of PCs currently held; a PC maps to slot pc mod 4
    task automatic model_fetch(input logic [7:0] pc, input bit flushed, output bit h);
        h = cached[pc];
        if (h) hits++;
        else begin
            misses++;
            if (flushed) foreach (cached[p]) cached[p] = 1'b0;
            else begin
                foreach (cached[p]) if (p % 4 == int'(pc) % 4) cached[p] = 1'b0;
                cached[pc] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        foreach (cached[p]) cached[p] = 1'b0;
        hits = 0;
        misses = 0;
    endtask

    function automatic int sat(input int n, input int m);
        return n > m ? m : n;
    endfunction

    // drives one fetch; memory answers 'delay' request cycles after it appears; optional flush mid-request
    task automatic run_fetch(input logic [7:0] pc, input int delay, input int flush_at,
                             output int vcyc, output bit addr_ok, output bit flushed);
        vcyc = 0;
        addr_ok = 1'b1;
        flushed = 1'b0;
        current_pc = pc;
        core_state = CORE_FETCH;
        tick();
        core_state = CORE_EXECUTE;
        if (fetcher_state == FS_FETCHED) return;
        for (int i = 0; i < delay; i++) begin
            if (mem_read_valid) vcyc++;
            if (mem_read_address !== pc) addr_ok = 1'b0;
            flush = (i == flush_at);
            if (flush) flushed = 1'b1;
            if (i == delay - 1) begin
                mem_read_ready = 1'b1;
                mem_read_data = prog[pc];
            end
            tick();
            flush = 1'b0;
            mem_read_ready = 1'b0;
            mem_read_data = 16'($urandom);
        end
    endtask

    task automatic decode();
        core_state = CORE_DECODE;
        tick();
        core_state = CORE_IDLE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        tests_run++; if (fetcher_state !== FS_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d want 0", fetcher_state); end
        tests_run++; if (mem_read_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", mem_read_valid); end
        tests_run++; if (mem_read_address !== 8'h00) begin tests_failed++; $display("FAIL reset_addr got %h want 00", mem_read_address); end
        tests_run++; if (instruction !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr got %h want 0000", instruction); end
        tests_run++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin tests_failed++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_cold_miss();
        int v; bit ok, fl, h;
        run_fetch(8'h05, 3, -1, v, ok, fl);
        model_fetch(8'h05, fl, h);
        tests_run++; if (v != 3) begin tests_failed++; $display("FAIL cold_valid_cycles got %0d want 3", v); end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL cold_addr got %h want 05", mem_read_address); end
        tests_run++; if (fetcher_state !== FS_FETCHED || mem_read_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_done got state %0d valid %b want 2/0", fetcher_state, mem_read_valid); end
        tests_run++; if (instruction !== 16'h3123) begin tests_failed++; $display("FAIL cold_instr got %h want 3123", instruction); end
        tests_run++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin tests_failed++; $display("FAIL cold_counts got %0d/%0d want 0/1", hit_count, miss_count); end
    endtask

    task automatic test_hit();
        int v; bit ok, fl, h;
        decode();
        tests_run++; if (fetcher_state !== FS_IDLE) begin tests_failed++; $display("FAIL hit_decode_idle got %0d want 0", fetcher_state); end
        run_fetch(8'h05, 3, -1, v, ok, fl);
        model_fetch(8'h05, fl, h);
        tests_run++; if (v != 0 || fetcher_state !== FS_FETCHED) begin tests_failed++; $display("FAIL hit_latency got valid_cycles %0d state %0d want 0/2", v, fetcher_state); end
        tests_run++; if (instruction !== 16'h3123) begin tests_failed++; $display("FAIL hit_instr got %h want 3123", instruction); end
        tests_run++; if (hit_count !== 16'd1) begin tests_failed++; $display("FAIL hit_count got %0d want 1", hit_count); end
    endtask

    task automatic test_conflict();
        int v; bit ok, fl, h;
        logic [7:0] seq [3] = '{8'h01, 8'h05, 8'h01};
        foreach (seq[k]) begin
            decode();
            run_fetch(seq[k], 2, -1, v, ok, fl);
            model_fetch(seq[k], fl, h);
            tests_run++; if (v != 2 || !ok) begin tests_failed++; $display("FAIL conflict_%0d got valid_cycles %0d addr %h want 2/%h", k, v, mem_read_address, seq[k]); end
            tests_run++; if (instruction !== prog[seq[k]]) begin tests_failed++; $display("FAIL conflict_instr_%0d got %h want %h", k, instruction, prog[seq[k]]); end
        end
        tests_run++; if (miss_count !== 16'(misses) || misses != 4) begin tests_failed++; $display("FAIL conflict_misses got %0d want 4", miss_count); end
    endtask

    task automatic test_flush_race();
        int v; bit ok, fl, h;
        decode();
        run_fetch(8'h07, 3, 1, v, ok, fl);
        model_fetch(8'h07, fl, h);
        tests_run++; if (instruction !== prog[8'h07]) begin tests_failed++; $display("FAIL flush_deliver got %h want %h", instruction, prog[8'h07]); end
        decode();
        run_fetch(8'h07, 2, -1, v, ok, fl);
        model_fetch(8'h07, fl, h);
        tests_run++; if (v != 2 || hit_count !== 16'(hits)) begin tests_failed++; $display("FAIL flush_refetch got valid_cycles %0d hits %0d want 2/%0d", v, hit_count, hits); end
        tests_run++; if (instruction !== prog[8'h07]) begin tests_failed++; $display("FAIL flush_refetch_instr got %h want %h", instruction, prog[8'h07]); end
    endtask

    task automatic test_stability();
        logic [15:0] held;
        held = instruction;
        core_state = CORE_UPDATE;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (fetcher_state !== FS_FETCHED || instruction !== held) begin tests_failed++; $display("FAIL hold_fetched_%0d got state %0d instr %h want 2/%h", i, fetcher_state, instruction, held); end
        end
        core_state = CORE_DECODE;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (fetcher_state !== FS_IDLE || instruction !== held) begin tests_failed++; $display("FAIL hold_decode_%0d got state %0d instr %h want 0/%h", i, fetcher_state, instruction, held); end
        end
        core_state = CORE_IDLE;
        for (int i = 0; i < 3; i++) begin
            mem_read_ready = 1'b1;
            mem_read_data = ~held;
            tick();
            mem_read_ready = 1'b0;
            tests_run++; if (fetcher_state !== FS_IDLE || instruction !== held || mem_read_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_ready_%0d got state %0d instr %h valid %b want 0/%h/0", i, fetcher_state, instruction, mem_read_valid, held); end
        end
    endtask

    task automatic test_reset_mid();
        int v; bit ok, fl, h;
        current_pc = 8'h09;
        core_state = CORE_FETCH;
        tick();
        core_state = CORE_IDLE;
        tests_run++; if (mem_read_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_request got %b want 1", mem_read_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tests_run++; if (fetcher_state !== FS_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin tests_failed++; $display("FAIL rmid_state got %0d/%b/%h want 0/0/00", fetcher_state, mem_read_valid, mem_read_address); end
        tests_run++; if (instruction !== 16'h0 || hit_count !== 16'h0 || miss_count !== 16'h0) begin tests_failed++; $display("FAIL rmid_regs got %h/%0d/%0d want 0/0/0", instruction, hit_count, miss_count); end
        run_fetch(8'h09, 2, -1, v, ok, fl);
        model_fetch(8'h09, fl, h);
        tests_run++; if (v != 2 || !ok || instruction !== prog[8'h09] || miss_count !== 16'd1) begin tests_failed++; $display("FAIL rmid_restart got cycles %0d instr %h misses %0d want 2/%h/1", v, instruction, miss_count, prog[8'h09]); end
    endtask

    task automatic test_random();
        int v, d, fa; bit ok, fl, h; logic [7:0] pc;
        for (int n = 0; n < 250; n++) begin
            decode();
            pc = ($urandom_range(0, 7) == 0) ? 8'hFF - 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 11));
            d = $urandom_range(1, 4);
            fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, d - 1) : -1;
            run_fetch(pc, d, fa, v, ok, fl);
            model_fetch(pc, fl, h);
            tests_run++; if (v != (h ? 0 : d) || (!h && !ok)) begin tests_failed++; $display("FAIL rand_%0d_path pc %h got valid_cycles %0d addr %h want %0d", n, pc, v, mem_read_address, h ? 0 : d); end
            tests_run++; if (fetcher_state !== FS_FETCHED || instruction !== prog[pc]) begin tests_failed++; $display("FAIL rand_%0d_instr pc %h got state %0d instr %h want 2/%h", n, pc, fetcher_state, instruction, prog[pc]); end
            tests_run++; if (hit_count !== 16'(sat(hits, 65535)) || miss_count !== 16'(sat(misses, 65535))) begin tests_failed++; $display("FAIL rand_%0d_counts got %0d/%0d want %0d/%0d", n, hit_count, miss_count, hits, misses); end
            tests_run++; if (s_hit_count !== 4'(sat(hits, 15)) || s_miss_count !== 4'(sat(misses, 15))) begin tests_failed++; $display("FAIL rand_%0d_sat got %0d/%0d want %0d/%0d", n, s_hit_count, s_miss_count, sat(hits, 15), sat(misses, 15)); end
        end
    endtask

    task automatic test_saturation();
        int v; bit ok, fl, h;
        for (int n = 0; n < 40; n++) begin
            decode();
            run_fetch(8'h02, 2, -1, v, ok, fl);
            model_fetch(8'h02, fl, h);
        end
        tests_run++; if (s_hit_count !== 4'hF) begin tests_failed++; $display("FAIL sat_hits got %h want f", s_hit_count); end
        tests_run++; if (hit_count !== 16'(sat(hits, 65535))) begin tests_failed++; $display("FAIL sat_wide_hits got %0d want %0d", hit_count, hits); end
        tests_run++; if (instruction !== prog[8'h02]) begin tests_failed++; $display("FAIL sat_instr got %h want %h", instruction, prog[8'h02]); end
    endtask

    initial begin
        foreach (prog[p]) prog[p] = 16'($urandom);
        prog[8'h05] = 16'h3123;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_race();
        test_stability();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
